serial_gt_comparator_lsb: RTL and testbench
===========================================

Name: serial_gt_comparator_lsb

Overview:
- Iterative, bit-serial magnitude comparator for the absdiff datapath.
- Takes the opposite scan direction to the ripple comparator chain: operands are consumed LSB-first, one bit per cycle.
- A running "greater-than-so-far" state register replaces the MSB-to-LSB done-ripple.
- Operands arrive on a val/rdy input stream. Results {gt, eq} leave on a val/rdy output stream. This lets the absdiff control unit choose the subtraction order without an NBITS-wide comparator chain.

Parameters:
- NBITS, 8: operand width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- istream_val  input  1  the operand pair on in0/in1 is valid.
- istream_rdy  output  1  the block can accept an operand pair.
- in0  input  NBITS  first operand, unsigned.
- in1  input  NBITS  second operand, unsigned.
- ostream_val  output  1  the result on gt/eq is valid.
- ostream_rdy  input  1  the consumer accepts the result.
- gt  output  1  1 iff in0 > in1 (unsigned).
- eq  output  1  1 iff in0 == in1.

Behaviour:
- Reset, asynchronous while rst=1:
  - state=IDLE, count=0.
  - Operand shift registers a_reg/b_reg=0.
  - gt_reg=0, eq_reg=0.
  - Outputs while in reset: istream_rdy=1, ostream_val=0, gt=0, eq=0.
- gt and eq are driven directly from gt_reg and eq_reg. They are meaningful only when ostream_val=1 but are always deterministic.
- FSM states: IDLE, CALC, DONE.
  - IDLE: istream_rdy=1, ostream_val=0.
    - On istream_val=1: load a_reg=in0, b_reg=in1, gt_reg=0, eq_reg=1, count=0; go to CALC.
    - Otherwise stay in IDLE.
  - CALC: istream_rdy=0, ostream_val=0. Each cycle, with a0=a_reg[0] and b0=b_reg[0]:
    - gt_reg <= (a0 & ~b0) | (~(a0 ^ b0) & gt_reg). A higher-order differing bit overrides any lower-order result.
    - eq_reg <= eq_reg & ~(a0 ^ b0).
    - a_reg and b_reg shift right by 1, filling with 0.
    - count <= count + 1.
    - When count == NBITS-1, the update in that cycle processes the MSB; next state is DONE.
  - DONE: istream_rdy=0, ostream_val=1, gt/eq held stable.
    - On ostream_rdy=1: go to IDLE.
    - Otherwise hold indefinitely (back-pressure) with no change to gt_reg or eq_reg.
- Latency:
  - If an operand pair is accepted on the edge ending cycle k, CALC occupies cycles k+1 .. k+NBITS.
  - ostream_val=1 first in cycle k+NBITS+1.
  - With ostream_rdy held at 1, istream_rdy returns to 1 in cycle k+NBITS+2.
  - Throughput is one comparison per NBITS+2 cycles.
- No overlap or bypass:
  - A new operand pair is never accepted in CALC or DONE; istream_val is ignored there.
  - There is no same-cycle DONE-to-accept path.
- Inputs in0/in1 are sampled only on the accept edge. Later changes to them have no effect.
- count width is clog2(NBITS); count never exceeds NBITS-1.
- The invariant gt & eq == 0 holds whenever ostream_val=1.
- Reset mid-operation, in CALC or DONE: return to IDLE immediately and asynchronously with reset values. The in-flight comparison is discarded and no result is produced.

Test Plan:
- Basic, NBITS=8. Send in0=8'h05, in1=8'h03 with ostream_rdy=1. Required:
  - istream_rdy falls the cycle after accept.
  - ostream_val=1 exactly 9 cycles after the accept edge, with gt=1, eq=0.
  - istream_rdy=1 one cycle later.
- MSB-dominance cases, each must yield gt=0, eq=1 or the stated result:
  - 8'h80 vs 8'h7F -> gt=1, eq=0, even though every lower bit favours in1.
  - 8'h7F vs 8'h80 -> gt=0, eq=0.
  - 8'hA5 vs 8'hA5 -> gt=0, eq=1.
  - 8'h00 vs 8'h00 -> gt=0, eq=1.
  - 8'hFF vs 8'hFE -> gt=1, eq=0.
- Exhaustive 1-bit-pair patterns at NBITS=2: all 16 combinations of in0, in1 in 0..3. gt and eq must match the unsigned compare; latency is 3 cycles to ostream_val.
- Back-pressure: hold ostream_rdy=0 for 5 cycles in DONE with in0=8'h10, in1=8'h20.
  - ostream_val stays 1 and gt=0, eq=0 are stable.
  - Toggling in0/in1 and istream_val during CALC and DONE changes nothing.
  - Raising ostream_rdy gives IDLE next cycle.
- Reset mid-operation: assert rst in the 4th CALC cycle. Immediately (before the next edge) istream_rdy=1, ostream_val=0, gt=0, eq=0. After deassert, 8'h03 vs 8'h02 yields gt=1, eq=0 with normal latency.
- Random: 200 random 8-bit pairs with random ostream_rdy stalls are checked against a reference compare. No result may be lost or duplicated.

Source files
------------

// File: rtl/serial_gt_comparator_lsb_if.sv
// Operand and result streams of the LSB-first serial comparator.
// master drives operands and result-ready; slave is the comparator.
interface serial_gt_comparator_lsb_if #(
  parameter int NBITS = 8
);
  logic             istream_val;
  logic             istream_rdy;
  logic [NBITS-1:0] in0;
  logic [NBITS-1:0] in1;
  logic             ostream_val;
  logic             ostream_rdy;
  logic             gt;
  logic             eq;

  modport master (
    output istream_val, in0, in1, ostream_rdy,
    input  istream_rdy, ostream_val, gt, eq
  );

  modport slave (
    input  istream_val, in0, in1, ostream_rdy,
    output istream_rdy, ostream_val, gt, eq
  );
endinterface

// File: rtl/serial_gt_comparator_lsb.sv
// Bit-serial unsigned magnitude comparator, operands consumed LSB-first.
// Accept -> result valid after NBITS+1 cycles; result held in DONE until ostream_rdy.
module serial_gt_comparator_lsb #(
  parameter int NBITS = 8
) (
  input logic                       clk,
  input logic                       rst,
  serial_gt_comparator_lsb_if.slave io
);
  localparam int              CW   = $clog2(NBITS);
  localparam logic [CW-1:0]   LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] a_reg;
  logic [NBITS-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             gt_reg;
  logic             eq_reg;
  logic             a0;
  logic             b0;
  logic             last_bit;

  assign a0       = a_reg[0];
  assign b0       = b_reg[0];
  assign last_bit = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.istream_val) state_nxt = CALC;
      CALC:    if (last_bit)       state_nxt = DONE;
      DONE:    if (io.ostream_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.istream_rdy = (state == IDLE);
    io.ostream_val = (state == DONE);
  end

  // Later (higher-order) bits are seen last, so a differing bit simply overwrites gt_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      count  <= '0;
      gt_reg <= 1'b0;
      eq_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.istream_val) begin
            a_reg  <= io.in0;
            b_reg  <= io.in1;
            count  <= '0;
            gt_reg <= 1'b0;
            eq_reg <= 1'b1;
          end
        end
        CALC: begin
          gt_reg <= (a0 & ~b0) | (~(a0 ^ b0) & gt_reg);
          eq_reg <= eq_reg & ~(a0 ^ b0);
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= last_bit ? '0 : count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io.gt = gt_reg;
  assign io.eq = eq_reg;
endmodule

// File: tb/tb_serial_gt_comparator_lsb.sv
// Scoreboard bench: drivers push expected {gt,eq,accept cycle}; monitors pop on result handshake.
module tb_serial_gt_comparator_lsb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_gt_comparator_lsb_if #(.NBITS(8)) if8 ();
  serial_gt_comparator_lsb_if #(.NBITS(2)) if2 ();

  serial_gt_comparator_lsb #(.NBITS(8)) dut8 (.clk(clk), .rst(rst), .io(if8));
  serial_gt_comparator_lsb #(.NBITS(2)) dut2 (.clk(clk), .rst(rst), .io(if2));

  typedef struct {
    logic gt;
    logic eq;
    int   acc;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random stalls, 2: never ready

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- monitors ----------------
  logic prev8 = 1'b0, prev2 = 1'b0;
  bit   ack8 = 1'b0, ack2 = 1'b0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (ack8) begin
        chk("rdy_after_ack8", if8.istream_rdy, 1);
        ack8 = 1'b0;
      end
      if8.ostream_rdy = pick_rdy();
      if (if8.ostream_val) begin
        chk("excl8", if8.gt & if8.eq, 0);
        if (q8.size() == 0) chk("spurious8", q8.size(), 1);
        else begin
          if (!prev8) chk("lat8", cyc - q8[0].acc, 9);
          if (if8.ostream_rdy) begin
            exp_t e;
            e = q8.pop_front();
            chk("gt8", if8.gt, e.gt);
            chk("eq8", if8.eq, e.eq);
            ack8 = 1'b1;
          end
        end
      end
      prev8 = if8.ostream_val;
    end
  end

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (ack2) begin
        chk("rdy_after_ack2", if2.istream_rdy, 1);
        ack2 = 1'b0;
      end
      if2.ostream_rdy = pick_rdy();
      if (if2.ostream_val) begin
        chk("excl2", if2.gt & if2.eq, 0);
        if (q2.size() == 0) chk("spurious2", q2.size(), 1);
        else begin
          if (!prev2) chk("lat2", cyc - q2[0].acc, 3);
          if (if2.ostream_rdy) begin
            exp_t e;
            e = q2.pop_front();
            chk("gt2", if2.gt, e.gt);
            chk("eq2", if2.eq, e.eq);
            ack2 = 1'b1;
          end
        end
      end
      prev2 = if2.ostream_val;
    end
  end

  // ---------------- drivers ----------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit track);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #1;
      ok = if8.istream_rdy;
    end
    if (!ok) begin
      timeout("accept8");
      return;
    end
    if8.in0 = a;
    if8.in1 = b;
    if8.istream_val = 1'b1;
    if (track) q8.push_back('{gt: (a > b), eq: (a == b), acc: cyc});
    @(posedge clk); #1;
    if8.istream_val = 1'b0;
    if8.in0 = 8'($urandom);
    if8.in1 = 8'($urandom);
    chk("rdy_drop8", if8.istream_rdy, 0);
  endtask

  task automatic send2(input logic [1:0] a, input logic [1:0] b);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #1;
      ok = if2.istream_rdy;
    end
    if (!ok) begin
      timeout("accept2");
      return;
    end
    if2.in0 = a;
    if2.in1 = b;
    if2.istream_val = 1'b1;
    q2.push_back('{gt: (a > b), eq: (a == b), acc: cyc});
    @(posedge clk); #1;
    if2.istream_val = 1'b0;
    if2.in0 = 2'($urandom);
    if2.in1 = 2'($urandom);
    chk("rdy_drop2", if2.istream_rdy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (q8.size() == 0 && q2.size() == 0 && if8.istream_rdy && if2.istream_rdy) return;
      @(posedge clk); #1;
    end
    timeout("drain");
  endtask

  logic [7:0] msb_a[5] = '{8'h80, 8'h7F, 8'hA5, 8'h00, 8'hFF};
  logic [7:0] msb_b[5] = '{8'h7F, 8'h80, 8'hA5, 8'h00, 8'hFE};

  initial begin
    if8.istream_val = 1'b0; if8.in0 = '0; if8.in1 = '0; if8.ostream_rdy = 1'b1;
    if2.istream_val = 1'b0; if2.in0 = '0; if2.in1 = '0; if2.ostream_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irdy", if8.istream_rdy, 1);
    chk("rst_oval", if8.ostream_val, 0);
    chk("rst_gt",   if8.gt, 0);
    chk("rst_eq",   if8.eq, 0);
    rst = 1'b0;

    // basic and MSB-dominance cases
    send8(8'h05, 8'h03, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) begin
      send8(msb_a[i], msb_b[i], 1'b1);
      drain();
    end

    // every 2-bit operand pair
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        send2(2'(a), 2'(b));
    drain();

    // back-pressure with operand/valid noise during CALC and DONE
    rdy_mode = 2;
    send8(8'h10, 8'h20, 1'b1);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        if8.istream_val = 1'($urandom);
        if8.in0 = 8'($urandom);
        if8.in1 = 8'($urandom);
        @(posedge clk); #1;
        seen = if8.ostream_val;
      end
      if (!seen) timeout("bp_val");
    end
    for (int n = 0; n < 5; n++) begin
      chk("bp_val", if8.ostream_val, 1);
      chk("bp_gt",  if8.gt, 0);
      chk("bp_eq",  if8.eq, 0);
      if8.istream_val = 1'($urandom);
      if8.in0 = 8'($urandom);
      if8.in1 = 8'($urandom);
      @(posedge clk); #1;
    end
    if8.istream_val = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    chk("bp_idle_rdy", if8.istream_rdy, 1);
    chk("bp_idle_val", if8.ostream_val, 0);
    drain();

    // reset in the 4th CALC cycle discards the operation
    send8(8'h55, 8'h11, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_irdy", if8.istream_rdy, 1);
    chk("mid_rst_oval", if8.ostream_val, 0);
    chk("mid_rst_gt",   if8.gt, 0);
    chk("mid_rst_eq",   if8.eq, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send8(8'h03, 8'h02, 1'b1);
    drain();

    // random pairs with random result stalls
    rdy_mode = 1;
    for (int i = 0; i < 200; i++)
      send8(8'($urandom), 8'($urandom), 1'b1);
    drain();
    chk("q8_left", q8.size(), 0);
    chk("q2_left", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
